// File: rtl/cpu_step_ctrl.sv
// Step/run controller for a single-cycle CPU: button edge pulses, HALT/STEP/RUN clock-enable
// generation with optional slow-run divider, and an issued-cycle counter.
module cpu_step_ctrl #(
    parameter int unsigned SLOW_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn_ok,
    input  logic [7:0]       sw_ok,
    output logic             cpu_en,
    output logic [3:0]       btn_pulse,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned DIV_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SLOW_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [3:0]       btn_q;
    logic             slow_q;
    logic             unused_sw;

    assign unused_sw = ^{sw_ok[7:2], sw_ok[0]};

    // btn_q resets high so a button held through reset never produces a pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HALT;
            div       <= '0;
            btn_q     <= 4'b1111;
            btn_pulse <= 4'b0000;
            slow_q    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            div       <= div_nxt;
            btn_q     <= btn_ok;
            btn_pulse <= btn_ok & ~btn_q;
            slow_q    <= sw_ok[1];
            if (btn_pulse[2]) begin
                cycle_cnt <= '0;
            end else if (cpu_en) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and enable decode; cpu_en depends only on registered state, div and slow_q
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        cpu_en    = 1'b0;
        running   = 1'b0;
        case (state)
            S_HALT: begin
                if (btn_pulse[1]) begin
                    state_nxt = S_RUN;
                end else if (btn_pulse[0]) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                cpu_en    = 1'b1;
                state_nxt = S_HALT;
            end
            S_RUN: begin
                running = 1'b1;
                cpu_en  = !slow_q || (div == DIV_MAX);
                // div only advances while slow mode is both registered and still selected
                if (slow_q && sw_ok[1]) begin
                    div_nxt = (div == DIV_MAX) ? '0 : div + DIV_W'(1);
                end
                if (btn_pulse[1]) begin
                    state_nxt = S_HALT;
                    div_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

endmodule
